iob_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one downstream resource among N requesters.

---
 rtl/iob_rr_arbiter_pkg.sv | 11 +
 rtl/iob_ctls.sv | 38 +++
 rtl/iob_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_iob_rr_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/iob_rr_arbiter_pkg.sv
// rtl/iob_rr_arbiter_pkg.sv - shared configuration and state encoding for the round-robin arbiter
package iob_rr_arbiter_pkg;

  localparam int IOB_RR_ARBITER_N = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/iob_ctls.sv
// rtl/iob_ctls.sv - count leading/trailing zeros or ones of a W-bit vector
module iob_ctls #(
  parameter int W      = 32,
  parameter int MODE   = 0,   // 0: trailing (from bit 0), 1: leading (from bit W-1)
  parameter int SYMBOL = 0    // 0: count zeros, 1: count ones
) (
  input  logic [W-1:0]             data_i,
  output logic [$clog2(W+1)-1:0]   count_o
);

  localparam int CW = $clog2(W+1);

  logic [W-1:0] data_sym;
  logic [W-1:0] data_ord;

  // Counting a symbol is finding the first bit of the opposite value.
  assign data_sym = (SYMBOL != 0) ? ~data_i : data_i;

  always_comb begin
    data_ord = data_sym;
    if (MODE != 0) begin
      for (int i = 0; i < W; i++) begin
        data_ord[i] = data_sym[W-1-i];
      end
    end
  end

  // An all-symbol input reports W.
  always_comb begin
    count_o = CW'(W);
    for (int i = W - 1; i >= 0; i--) begin
      if (data_ord[i]) begin
        count_o = CW'(i);
      end
    end
  end

endmodule

// File: rtl/iob_rr_arbiter.sv
// rtl/iob_rr_arbiter.sv - locking round-robin arbiter with zero-bubble hand-over
module iob_rr_arbiter
  import iob_rr_arbiter_pkg::*;
#(
  parameter  int N     = IOB_RR_ARBITER_N,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             cke_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             done_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_valid_o
);

  localparam int CW = $clog2(N+1);
  localparam int SW = IDX_W + 2;

  arb_state_t       state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] grant_idx, grant_idx_n;
  logic             grant_valid, grant_valid_n;

  logic [IDX_W-1:0] rel_base;
  logic [N-1:0]     req_mask;
  logic [N-1:0]     rot_idle, rot_rel;
  logic [CW-1:0]    off_idle, off_rel;
  logic [IDX_W-1:0] cand_idle, cand_rel;
  logic             any_idle, any_rel;
  logic             release_w;

  function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input logic [IDX_W-1:0] b);
    logic [N-1:0] r;
    int           j;
    r = '0;
    for (int i = 0; i < N; i++) begin
      j = i + int'(b);
      if (j >= N) j = j - N;
      r[i] = v[j];
    end
    return r;
  endfunction

  // base + off never exceeds 2N-2, so one conditional subtract is a full modulo.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] b, input logic [CW-1:0] o);
    logic [SW-1:0] s;
    s = SW'(b) + SW'(o);
    if (s >= SW'(N)) s = s - SW'(N);
    return s[IDX_W-1:0];
  endfunction

  assign rel_base  = (grant_idx == IDX_W'(N-1)) ? '0 : grant_idx + IDX_W'(1);
  assign req_mask  = req_i & ~(N'(1) << grant_idx);
  assign rot_idle  = rotr(req_i, ptr);
  assign rot_rel   = rotr(req_mask, rel_base);
  assign any_idle  = |req_i;
  assign any_rel   = |req_mask;
  assign cand_idle = wrap_add(ptr, off_idle);
  assign cand_rel  = wrap_add(rel_base, off_rel);
  assign release_w = done_i | ~req_i[grant_idx];

  iob_ctls #(.W(N), .MODE(0), .SYMBOL(0)) u_ctz_idle (
    .data_i  (rot_idle),
    .count_o (off_idle)
  );

  iob_ctls #(.W(N), .MODE(0), .SYMBOL(0)) u_ctz_rel (
    .data_i  (rot_rel),
    .count_o (off_rel)
  );

  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    grant_idx_n   = grant_idx;
    grant_valid_n = grant_valid;
    case (state)
      ST_IDLE: begin
        if (any_idle) begin
          grant_idx_n   = cand_idle;
          grant_valid_n = 1'b1;
          state_n       = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (release_w) begin
          ptr_n = rel_base;
          // The releasing requester is masked so it cannot win this edge.
          if (any_rel) begin
            grant_idx_n = cand_rel;
          end else begin
            grant_idx_n   = '0;
            grant_valid_n = 1'b0;
            state_n       = ST_IDLE;
          end
        end
      end
      default: begin
        state_n       = ST_IDLE;
        grant_idx_n   = '0;
        grant_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else if (cke_i) begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant_idx   <= grant_idx_n;
      grant_valid <= grant_valid_n;
    end
  end

  assign grant_o       = grant_valid ? (N'(1) << grant_idx) : '0;
  assign grant_idx_o   = grant_idx;
  assign grant_valid_o = grant_valid;

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// tb/tb_iob_rr_arbiter.sv - self-checking bench for iob_rr_arbiter (N=4 and N=3)
module tb_iob_rr_arbiter;

  logic       clk = 1'b0;
  logic       cke, rst, done;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;

  logic       rst3, done3;
  logic [2:0] req3;
  logic [2:0] grant3;
  logic [1:0] grant_idx3;
  logic       grant_valid3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iob_rr_arbiter #(.N(4)) dut (
    .clk_i         (clk),
    .cke_i         (cke),
    .rst_i         (rst),
    .req_i         (req),
    .done_i        (done),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  iob_rr_arbiter #(.N(3)) dut3 (
    .clk_i         (clk),
    .cke_i         (1'b1),
    .rst_i         (rst3),
    .req_i         (req3),
    .done_i        (done3),
    .grant_o       (grant3),
    .grant_idx_o   (grant_idx3),
    .grant_valid_o (grant_valid3)
  );

  typedef struct {
    logic       rst;
    logic       cke;
    logic [3:0] req;
    logic       done;
    logic       vld;
    int         idx;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic r, input logic c, input logic [3:0] q, input logic d,
                      input logic v, input int i);
    vec_t e;
    e.rst = r; e.cke = c; e.req = q; e.done = d; e.vld = v; e.idx = i;
    vt.push_back(e);
  endtask

  // Reference model: current grantee (-1 when none) and rotating start pointer.
  int m_ptr = 0;
  int m_cur = -1;

  task automatic model_step(input logic r, input logic c, input logic [3:0] q, input logic d);
    int prev;
    int idx;
    int found;
    if (r) begin
      m_cur = -1;
      m_ptr = 0;
    end else if (c) begin
      if (m_cur < 0) begin
        found = -1;
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (found < 0 && q[idx]) found = idx;
        end
        m_cur = found;
      end else if (d || !q[m_cur]) begin
        prev  = m_cur;
        m_ptr = (prev + 1) % 4;
        found = -1;
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (found < 0 && idx != prev && q[idx]) found = idx;
        end
        m_cur = found;
      end
    end
  endtask

  initial begin
    int exp_idx;
    int exp_vld;
    cke = 1'b1; rst = 1'b1; req = '0; done = 1'b0;
    rst3 = 1'b1; req3 = '0; done3 = 1'b0;

    //   rst  cke  req     done vld idx
    addv(1, 1, 4'b1111, 0, 0, 0);
    addv(1, 1, 4'b1111, 0, 0, 0);
    addv(0, 1, 4'b1111, 0, 1, 0);
    addv(0, 1, 4'b1111, 1, 1, 1);
    addv(0, 1, 4'b1111, 1, 1, 2);
    addv(0, 1, 4'b1111, 1, 1, 3);
    addv(0, 1, 4'b1111, 1, 1, 0);
    addv(0, 1, 4'b1111, 0, 1, 0);
    addv(0, 1, 4'b0100, 0, 1, 2);
    addv(0, 1, 4'b0000, 0, 0, 0);
    addv(0, 1, 4'b0101, 0, 1, 0);
    addv(0, 1, 4'b0101, 1, 1, 2);
    addv(0, 1, 4'b0101, 1, 1, 0);
    addv(0, 1, 4'b0010, 1, 1, 1);
    addv(0, 1, 4'b1000, 0, 1, 3);
    addv(0, 0, 4'b0111, 1, 1, 3);
    addv(0, 0, 4'b1111, 1, 1, 3);
    addv(0, 1, 4'b1010, 0, 1, 3);
    addv(0, 1, 4'b1111, 1, 1, 0);
    addv(0, 1, 4'b0100, 0, 1, 2);
    addv(1, 1, 4'b0100, 0, 0, 0);
    addv(0, 1, 4'b0100, 0, 1, 2);
    addv(0, 1, 4'b0000, 0, 0, 0);
    addv(0, 1, 4'b0000, 1, 0, 0);
    addv(0, 0, 4'b0010, 0, 0, 0);
    addv(0, 1, 4'b0010, 0, 1, 1);
    addv(0, 1, 4'b0010, 1, 0, 0);
    addv(0, 1, 4'b0010, 0, 1, 1);

    for (int v = 0; v < vt.size(); v++) begin
      rst = vt[v].rst; cke = vt[v].cke; req = vt[v].req; done = vt[v].done;
      tick();
      check($sformatf("vec%0d_valid", v), int'(grant_valid), int'(vt[v].vld));
      check($sformatf("vec%0d_idx", v), int'(grant_idx), vt[v].idx);
      check($sformatf("vec%0d_grant", v), int'(grant), vt[v].vld ? (1 << vt[v].idx) : 0);
    end

    // N=3: non-power-of-two wrap with continuous requests.
    rst3 = 1'b1; req3 = 3'b111; done3 = 1'b0;
    tick();
    check("n3_reset_valid", int'(grant_valid3), 0);
    rst3 = 1'b0;
    tick();
    check("n3_first_idx", int'(grant_idx3), 0);
    check("n3_first_valid", int'(grant_valid3), 1);
    done3 = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      tick();
      check($sformatf("n3_seq%0d_idx", s), int'(grant_idx3), s % 3);
      check($sformatf("n3_seq%0d_grant", s), int'(grant3), 1 << (s % 3));
    end
    done3 = 1'b0;
    rst3  = 1'b1;

    // Randomized run against the reference model.
    rst = 1'b1; cke = 1'b1; req = '0; done = 1'b0;
    model_step(rst, cke, req, done);
    tick();
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 63) == 0);
      cke  = ($urandom_range(0, 7) != 0);
      req  = 4'($urandom) & 4'($urandom | $urandom);
      done = ($urandom_range(0, 2) == 0);
      model_step(rst, cke, req, done);
      tick();
      exp_vld = (m_cur >= 0) ? 1 : 0;
      exp_idx = (m_cur >= 0) ? m_cur : 0;
      check("rnd_valid", int'(grant_valid), exp_vld);
      check("rnd_idx", int'(grant_idx), exp_idx);
      check("rnd_grant", int'(grant), exp_vld ? (1 << exp_idx) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
